// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit: D-stage stall detection, D/E/M operand forwarding, MDU busy tracking.
// Latency: stall, flush and forwarding are combinational; history and MDU counter update on clk.
// Backpressure: stall freezes PC and F/D, flush_e bubbles D/E; HAZARD_PERF_EN adds stall_cnt.
module pipe_hazard_ctrl #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int NSRC     = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NSRC*AW-1:0] d_src_a,
   input  logic [NSRC*DW-1:0] d_src_v,
   input  logic [NSRC*2-1:0]  d_src_tuse,
   input  logic               d_mdu,
   input  logic [NSRC*AW-1:0] e_src_a,
   input  logic [NSRC*DW-1:0] e_src_v,
   input  logic [AW-1:0]      m_rt_a,
   input  logic [DW-1:0]      m_rt_v,
   input  logic [AW-1:0]      e_wa,
   input  logic [AW-1:0]      m_wa,
   input  logic [AW-1:0]      w_wa,
   input  logic [DW-1:0]      e_wv,
   input  logic [DW-1:0]      m_wv,
   input  logic [DW-1:0]      w_wv,
   input  logic [1:0]         e_tnew,
   input  logic [1:0]         m_tnew,
   input  logic               mdu_start,
   input  logic               mdu_op,
   output logic               stall,
   output logic               flush_e,
   output logic               mdu_busy,
   output logic [NSRC*DW-1:0] fwd_d,
   output logic [NSRC*DW-1:0] fwd_e,
   output logic [DW-1:0]      fwd_m_rt
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
   localparam logic [1:0] TUSE_NONE = 2'd3;

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wv;
   } wr_t;

   // Register 0 is hard-wired, so a zero destination never matches anything.
   function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] wa);
      return (a == wa) && (wa != '0);
   endfunction

   wr_t           hist;
   logic [CW-1:0] mdu_cnt;
   logic [NSRC-1:0] data_stall;
   logic          mdu_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= '0;
      end else begin
         hist.wa <= w_wa;
         hist.wv <= w_wv;
      end
   end

   // A start pulse is only honoured when idle; the counter saturates at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdu_cnt <= '0;
      end else if (mdu_cnt != '0) begin
         mdu_cnt <= mdu_cnt - 1'b1;
      end else if (mdu_start) begin
         mdu_cnt <= mdu_op ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end
   end

   assign mdu_busy  = (mdu_cnt != '0);
   assign mdu_stall = d_mdu && (mdu_start || mdu_busy);

   for (genvar k = 0; k < NSRC; k++) begin : g_dsrc
      logic [AW-1:0] a;
      logic [1:0]    tuse;
      logic          he, hm, hw;

      assign a    = d_src_a[k*AW +: AW];
      assign tuse = d_src_tuse[k*2 +: 2];
      assign he   = hit(a, e_wa);
      assign hm   = hit(a, m_wa);
      assign hw   = hit(a, w_wa);

      // The E producer, when it matches, hides any older M producer.
      assign data_stall[k] = (tuse != TUSE_NONE) &&
                             ((he && (e_tnew > tuse)) || (!he && hm && (m_tnew > tuse)));

      assign fwd_d[k*DW +: DW] = (he && (e_tnew == 2'd0)) ? e_wv :
                                 (hm && (m_tnew == 2'd0)) ? m_wv :
                                 hw                       ? w_wv :
                                                            d_src_v[k*DW +: DW];
   end

   for (genvar k = 0; k < NSRC; k++) begin : g_esrc
      logic [AW-1:0] a;

      assign a = e_src_a[k*AW +: AW];
      assign fwd_e[k*DW +: DW] = hit(a, m_wa)    ? m_wv    :
                                 hit(a, w_wa)    ? w_wv    :
                                 hit(a, hist.wa) ? hist.wv :
                                                   e_src_v[k*DW +: DW];
   end

   assign fwd_m_rt = hit(m_rt_a, w_wa)    ? w_wv    :
                     hit(m_rt_a, hist.wa) ? hist.wv :
                                            m_rt_v;

   assign stall   = (|data_stall) || mdu_stall;
   assign flush_e = stall;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NSRC = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [NSRC*AW-1:0] d_src_a;
   logic [NSRC*DW-1:0] d_src_v;
   logic [NSRC*2-1:0]  d_src_tuse;
   logic               d_mdu;
   logic [NSRC*AW-1:0] e_src_a;
   logic [NSRC*DW-1:0] e_src_v;
   logic [AW-1:0]      m_rt_a;
   logic [DW-1:0]      m_rt_v;
   logic [AW-1:0]      e_wa, m_wa, w_wa;
   logic [DW-1:0]      e_wv, m_wv, w_wv;
   logic [1:0]         e_tnew, m_tnew;
   logic               mdu_start, mdu_op;
   logic               stall, flush_e, mdu_busy;
   logic [NSRC*DW-1:0] fwd_d, fwd_e;
   logic [DW-1:0]      fwd_m_rt;
`ifdef HAZARD_PERF_EN
   logic [31:0]        stall_cnt;
`endif

   int total = 0;
   int bad = 0;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .d_src_a(d_src_a), .d_src_v(d_src_v), .d_src_tuse(d_src_tuse), .d_mdu(d_mdu),
      .e_src_a(e_src_a), .e_src_v(e_src_v), .m_rt_a(m_rt_a), .m_rt_v(m_rt_v),
      .e_wa(e_wa), .m_wa(m_wa), .w_wa(w_wa), .e_wv(e_wv), .m_wv(m_wv), .w_wv(w_wv),
      .e_tnew(e_tnew), .m_tnew(m_tnew), .mdu_start(mdu_start), .mdu_op(mdu_op),
      .stall(stall), .flush_e(flush_e), .mdu_busy(mdu_busy),
      .fwd_d(fwd_d), .fwd_e(fwd_e), .fwd_m_rt(fwd_m_rt)
`ifdef HAZARD_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      d_src_a = '0; d_src_tuse = 4'hF; d_mdu = 1'b0;
      d_src_v = {32'h2000, 32'h1000};
      e_src_a = '0; e_src_v = {32'h4000, 32'h3000};
      m_rt_a = '0; m_rt_v = 32'h5000;
      e_wa = '0; m_wa = '0; w_wa = 5'd3;
      e_wv = 32'h77; m_wv = '0; w_wv = 32'h55;
      e_tnew = '0; m_tnew = '0; mdu_start = 1'b0; mdu_op = 1'b0;

      // Reset state: history cleared even though W held a write during reset.
      tick(); tick();
      w_wa = '0; e_src_a[0 +: AW] = 5'd3; #1;
      chk("rst_busy", 64'(mdu_busy), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_hist", 64'(fwd_e[0 +: DW]), 64'h3000);
      e_src_a = '0;
      reset = 1'b0;
      tick();

      // E producer not ready soon enough -> stall, then ready in time.
      e_wa = 5'd5; e_tnew = 2'd2; d_src_a[0 +: AW] = 5'd5; d_src_tuse = 4'b1101; #1;
      chk("e_stall", 64'(stall), 64'd1);
      chk("e_flush", 64'(flush_e), 64'd1);
      e_tnew = 2'd1; #1;
      chk("e_nostall", 64'(stall), 64'd0);
      chk("e_nofwd", 64'(fwd_d[0 +: DW]), 64'h1000);
      d_src_tuse = 4'hF; e_tnew = 2'd2; #1;
      chk("tuse3", 64'(stall), 64'd0);

      // M producer stall, then masked by a ready E producer.
      e_wa = '0; m_wa = 5'd5; m_tnew = 2'd1; d_src_tuse = 4'b1100; #1;
      chk("m_stall", 64'(stall), 64'd1);
      e_wa = 5'd5; e_tnew = 2'd0; #1;
      chk("m_masked", 64'(stall), 64'd0);
      chk("fwd_d_e", 64'(fwd_d[0 +: DW]), 64'h77);

      // Priority on D channel 1.
      d_src_tuse = 4'hF; d_src_a = '0; d_src_a[AW +: AW] = 5'd8;
      e_wa = 5'd8; e_tnew = 2'd0; e_wv = 32'h11;
      m_wa = 5'd8; m_tnew = 2'd0; m_wv = 32'h22; #1;
      chk("fwd_d1_e", 64'(fwd_d[DW +: DW]), 64'h11);
      e_tnew = 2'd1; #1;
      chk("fwd_d1_m", 64'(fwd_d[DW +: DW]), 64'h22);
      e_wa = '0; m_wa = '0; w_wa = 5'd8; w_wv = 32'h33; #1;
      chk("fwd_d1_w", 64'(fwd_d[DW +: DW]), 64'h33);

      // E and M-store forwarding.
      e_src_a[AW +: AW] = 5'd9; m_wa = 5'd9; m_wv = 32'h44; w_wa = 5'd9; w_wv = 32'h55; #1;
      chk("fwd_e1_m", 64'(fwd_e[DW +: DW]), 64'h44);
      m_wa = '0; m_rt_a = 5'd9; #1;
      chk("fwd_e1_w", 64'(fwd_e[DW +: DW]), 64'h55);
      chk("fwd_mrt_w", 64'(fwd_m_rt), 64'h55);

      // History holds last cycle's W write.
      e_src_a = '0; m_rt_a = '0;
      w_wa = 5'd3; w_wv = 32'hABCD;
      tick();
      w_wa = '0; w_wv = '0; e_src_a[0 +: AW] = 5'd3; m_rt_a = 5'd3; #1;
      chk("fwd_e0_hist", 64'(fwd_e[0 +: DW]), 64'hABCD);
      chk("fwd_mrt_hist", 64'(fwd_m_rt), 64'hABCD);
      e_src_a = '0; m_rt_a = '0;

      // Divide: stall in start cycle plus 10 busy cycles; restart ignored.
      tick();
      mdu_start = 1'b1; mdu_op = 1'b1; d_mdu = 1'b1; #1;
      chk("div_start_stall", 64'(stall), 64'd1);
      chk("div_start_busy", 64'(mdu_busy), 64'd0);
      tick();
      mdu_start = 1'b0; mdu_op = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("div_busy%0d", i), 64'(mdu_busy), 64'd1);
         chk($sformatf("div_stall%0d", i), 64'(stall), 64'd1);
         if (i == 3) mdu_start = 1'b1;
         tick();
         mdu_start = 1'b0;
      end
      chk("div_done_busy", 64'(mdu_busy), 64'd0);
      chk("div_done_stall", 64'(stall), 64'd0);

      // Multiply: 5 busy cycles, no stall without d_mdu.
      d_mdu = 1'b0; mdu_start = 1'b1; mdu_op = 1'b0;
      tick();
      mdu_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("mul_busy%0d", i), 64'(mdu_busy), 64'd1);
         chk($sformatf("mul_nostall%0d", i), 64'(stall), 64'd0);
         tick();
      end
      chk("mul_done", 64'(mdu_busy), 64'd0);

      // Reset mid-multiply aborts it.
      mdu_start = 1'b1;
      tick();
      mdu_start = 1'b0;
      tick(); tick();
      chk("mul_mid_busy", 64'(mdu_busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_abort_busy", 64'(mdu_busy), 64'd0);

      // Address 0 never matches.
      d_src_a = '0; d_src_tuse = 4'h0; e_wa = '0; e_tnew = 2'd3;
      m_wa = '0; m_tnew = 2'd3; w_wa = '0; w_wv = 32'h99; #1;
      chk("zero_stall", 64'(stall), 64'd0);
      chk("zero_fwd0", 64'(fwd_d[0 +: DW]), 64'h1000);
      chk("zero_fwd1", 64'(fwd_d[DW +: DW]), 64'h2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
